fifo_sync_flags: RTL and testbench

Parametrised single-clock FIFO: the successor to our fixed 4-bit × 8-entry buffer, generalised in width, depth and read mode. It adds an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and an optional first-word-fall-through (FWFT) read port. It sits between a data producer and a consumer inside the tile, and its status outputs map directly onto the user output pins.

---
 rtl/fifo_sync_flags.sv | 97 +++++++++
 tb/tb_fifo_sync_flags.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock parametrised FIFO with occupancy count, registered status flags,
// sticky overflow/underflow errors and a selectable registered or fall-through read port.
module fifo_sync_flags #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count_next;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags, so no request input reaches an output combinationally.
  assign wr_acc     = wr_en && !full;
  assign rd_acc     = rd_en && !empty;
  assign count_next = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + AW'(1);
      end
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AFULL_TH));
      almost_empty <= (count_next <= CW'(AEMPTY_TH));
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow     <= (overflow && !clr_err) || (wr_en && full);
      underflow    <= (underflow && !clr_err) || (rd_en && empty);
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= rd_acc;
          if (rd_acc) begin
            rdata <= mem[rptr];
          end
        end
      end
    end else begin : g_fwft_read
      // Head entry is presented from registered state only; zero while nothing is stored.
      assign rvalid = !empty;
      assign rdata  = empty ? '0 : mem[rptr];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed self-checking bench: a registered-read instance and a fall-through instance
// share one clock and reset; each task drives one scenario and checks its own outputs.
module tb_fifo_sync_flags;

  logic       clk;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [3:0] wdata;
  logic [3:0] rdata;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [3:0] f_wdata;
  logic [3:0] f_rdata;
  logic       f_rvalid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  int         n_cmp;
  int         n_fail;
  logic [3:0] q[$];

  fifo_sync_flags #(.WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .clr_err(clr_err),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_flags #(.WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en),
    .clr_err(f_clr_err), .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_en = 0; rd_en = 0; clr_err = 0; wdata = 0;
    do_reset();
    n_cmp++;
    if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_cmp++;
    if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0101", {full, empty, almost_full, almost_empty});
    end
    n_cmp++;
    if ({rvalid, rdata, overflow, underflow} !== 7'b0) begin
      n_fail++; $display("[TB] FAIL reset_read_err: got %b expected 0000000", {rvalid, rdata, overflow, underflow});
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1; wdata = 4'(i);
      tick();
      n_cmp++;
      if (count !== 4'(i)) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i); end
      n_cmp++;
      if ({full, almost_full, empty, almost_empty} !== {logic'(i == 8), logic'(i >= 6), 1'b0, logic'(i <= 2)}) begin
        n_fail++;
        $display("[TB] FAIL fill_flags: got %b expected %b at count %0d", {full, almost_full, empty, almost_empty},
                 {logic'(i == 8), logic'(i >= 6), 1'b0, logic'(i <= 2)}, i);
      end
    end
    wdata = 4'd9;
    tick();
    wr_en = 0;
    n_cmp++;
    if ({overflow, count} !== {1'b1, 4'd8}) begin
      n_fail++; $display("[TB] FAIL fill_overflow: got ovf=%b cnt=%0d expected ovf=1 cnt=8", overflow, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1;
      tick();
      n_cmp++;
      if ({rvalid, rdata} !== {1'b1, 4'(i)}) begin
        n_fail++; $display("[TB] FAIL drain_data: got v=%b d=%0h expected v=1 d=%0h", rvalid, rdata, i);
      end
      n_cmp++;
      if ({count, almost_empty} !== {4'(8 - i), logic'((8 - i) <= 2)}) begin
        n_fail++; $display("[TB] FAIL drain_count: got cnt=%0d ae=%b expected cnt=%0d", count, almost_empty, 8 - i);
      end
    end
    rd_en = 0;
    tick();
    n_cmp++;
    if ({rvalid, rdata, empty, almost_empty} !== {1'b0, 4'd8, 1'b1, 1'b1}) begin
      n_fail++; $display("[TB] FAIL drain_idle: got v=%b d=%0h e=%b ae=%b expected v=0 d=8 e=1 ae=1",
                         rvalid, rdata, empty, almost_empty);
    end
    rd_en = 1;
    tick();
    rd_en = 0;
    n_cmp++;
    if ({underflow, rvalid, overflow} !== 3'b101) begin
      n_fail++; $display("[TB] FAIL drain_underflow: got uf=%b v=%b ovf=%b expected uf=1 v=0 ovf=1",
                         underflow, rvalid, overflow);
    end
  endtask

  task automatic test_clear_err();
    clr_err = 1;
    tick();
    clr_err = 0;
    n_cmp++;
    if ({overflow, underflow} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL clear_err: got ovf=%b uf=%b expected 0 0", overflow, underflow);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp;
    q.delete();
    for (int i = 10; i <= 12; i++) begin
      wr_en = 1; wdata = 4'(i); q.push_back(4'(i));
      tick();
    end
    rd_en = 1;
    for (int k = 0; k < 10; k++) begin
      wdata = 4'(k);
      tick();
      exp = q.pop_front();
      q.push_back(4'(k));
      n_cmp++;
      if ({count, rvalid, rdata} !== {4'd3, 1'b1, exp}) begin
        n_fail++; $display("[TB] FAIL simul_rw: got cnt=%0d v=%b d=%0h expected cnt=3 v=1 d=%0h",
                           count, rvalid, rdata, exp);
      end
    end
    wr_en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = q.pop_front();
      n_cmp++;
      if ({rvalid, rdata} !== {1'b1, exp}) begin
        n_fail++; $display("[TB] FAIL simul_tail: got v=%b d=%0h expected v=1 d=%0h", rvalid, rdata, exp);
      end
    end
    rd_en = 0;
    tick();
    n_cmp++;
    if ({empty, underflow, overflow} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL simul_end: got e=%b uf=%b ovf=%b expected 1 0 0", empty, underflow, overflow);
    end
  endtask

  task automatic test_full_both();
    logic [3:0] exp_tail [8];
    exp_tail = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'hE};
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1; wdata = 4'(i);
      tick();
    end
    rd_en = 1; wdata = 4'hF;
    tick();
    n_cmp++;
    if ({count, overflow, full, rvalid, rdata} !== {4'd7, 1'b1, 1'b0, 1'b1, 4'd1}) begin
      n_fail++; $display("[TB] FAIL full_both: got cnt=%0d ovf=%b f=%b v=%b d=%0h expected 7 1 0 1 1",
                         count, overflow, full, rvalid, rdata);
    end
    rd_en = 0; wdata = 4'hE;
    tick();
    clr_err = 1;
    tick();
    n_cmp++;
    if ({overflow, count} !== {1'b1, 4'd8}) begin
      n_fail++; $display("[TB] FAIL clr_with_ovf: got ovf=%b cnt=%0d expected ovf=1 cnt=8", overflow, count);
    end
    wr_en = 0;
    tick();
    clr_err = 0;
    n_cmp++;
    if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_alone: got %b expected 0", overflow); end
    rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({rvalid, rdata} !== {1'b1, exp_tail[i]}) begin
        n_fail++; $display("[TB] FAIL full_order: got v=%b d=%0h expected v=1 d=%0h", rvalid, rdata, exp_tail[i]);
      end
    end
    rd_en = 0;
  endtask

  task automatic test_wrap();
    logic [3:0] v;
    logic [3:0] exp;
    logic       w, r;
    int         written, nread;
    written = 0; nread = 0;
    q.delete();
    do_reset();
    for (int i = 0; i < 200 && written < 20; i++) begin
      w = (written < 20) && (q.size() < 7) && (i % 4 != 3);
      r = (q.size() > 1) && (i % 4 != 0);
      v = 4'($urandom_range(0, 15));
      wr_en = w; rd_en = r; wdata = v;
      tick();
      if (r) begin
        exp = q.pop_front();
        nread++;
        n_cmp++;
        if ({rvalid, rdata} !== {1'b1, exp}) begin
          n_fail++; $display("[TB] FAIL wrap_data: got v=%b d=%0h expected v=1 d=%0h", rvalid, rdata, exp);
        end
      end else begin
        n_cmp++;
        if (rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_idle: got v=%b expected 0", rvalid); end
      end
      if (w) begin
        q.push_back(v);
        written++;
      end
      n_cmp++;
      if (count !== 4'(q.size())) begin
        n_fail++; $display("[TB] FAIL wrap_count: got %0d expected %0d", count, q.size());
      end
    end
    wr_en = 0; rd_en = 1;
    while (q.size() > 0) begin
      tick();
      exp = q.pop_front();
      nread++;
      n_cmp++;
      if ({rvalid, rdata} !== {1'b1, exp}) begin
        n_fail++; $display("[TB] FAIL wrap_drain: got v=%b d=%0h expected v=1 d=%0h", rvalid, rdata, exp);
      end
    end
    rd_en = 0;
    n_cmp++;
    if ({overflow, underflow, empty} !== 3'b001 || nread != 20) begin
      n_fail++; $display("[TB] FAIL wrap_end: got ovf=%b uf=%b e=%b reads=%0d expected 0 0 1 20",
                         overflow, underflow, empty, nread);
    end
  endtask

  task automatic test_reset_traffic();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1; wdata = 4'(i);
      tick();
    end
    rd_en = 1;
    tick();
    n_cmp++;
    if ({count, rvalid, rdata} !== {4'd5, 1'b1, 4'd1}) begin
      n_fail++; $display("[TB] FAIL pre_reset: got cnt=%0d v=%b d=%0h expected 5 1 1", count, rvalid, rdata);
    end
    rst_n = 0; wr_en = 1; rd_en = 1; wdata = 4'hE;
    tick();
    rst_n = 1; rd_en = 0; wdata = 4'hC;
    n_cmp++;
    if ({count, empty, almost_empty, full, almost_full} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL mid_reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b expected 0 1 1 0 0",
                         count, empty, almost_empty, full, almost_full);
    end
    n_cmp++;
    if ({rvalid, rdata, overflow, underflow} !== 7'b0) begin
      n_fail++; $display("[TB] FAIL mid_reset_read: got %b expected 0000000", {rvalid, rdata, overflow, underflow});
    end
    tick();
    wr_en = 0; rd_en = 1;
    tick();
    rd_en = 0;
    n_cmp++;
    if ({rvalid, rdata, count} !== {1'b1, 4'hC, 4'd0}) begin
      n_fail++; $display("[TB] FAIL post_reset_data: got v=%b d=%0h cnt=%0d expected 1 c 0", rvalid, rdata, count);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 0; f_rd_en = 0; f_wdata = 0;
    do_reset();
    n_cmp++;
    if ({f_rvalid, f_rdata, f_empty} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL fwft_reset: got v=%b d=%0h e=%b expected 0 0 1", f_rvalid, f_rdata, f_empty);
    end
    f_wr_en = 1; f_wdata = 4'hA;
    tick();
    f_wr_en = 0;
    n_cmp++;
    if ({f_rvalid, f_rdata, f_count} !== {1'b1, 4'hA, 4'd1}) begin
      n_fail++; $display("[TB] FAIL fwft_first: got v=%b d=%0h cnt=%0d expected 1 a 1", f_rvalid, f_rdata, f_count);
    end
    f_wr_en = 1; f_wdata = 4'h5;
    tick();
    f_wr_en = 0;
    n_cmp++;
    if ({f_rvalid, f_rdata, f_count} !== {1'b1, 4'hA, 4'd2}) begin
      n_fail++; $display("[TB] FAIL fwft_hold: got v=%b d=%0h cnt=%0d expected 1 a 2", f_rvalid, f_rdata, f_count);
    end
    f_rd_en = 1;
    tick();
    f_rd_en = 0;
    n_cmp++;
    if ({f_rvalid, f_rdata} !== {1'b1, 4'h5}) begin
      n_fail++; $display("[TB] FAIL fwft_next: got v=%b d=%0h expected 1 5", f_rvalid, f_rdata);
    end
    f_rd_en = 1;
    tick();
    n_cmp++;
    if ({f_rvalid, f_rdata, f_empty, f_underflow} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL fwft_empty: got v=%b d=%0h e=%b uf=%b expected 0 0 1 0",
                         f_rvalid, f_rdata, f_empty, f_underflow);
    end
    tick();
    f_rd_en = 0;
    n_cmp++;
    if (f_underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL fwft_underflow: got %b expected 1", f_underflow); end
  endtask

  initial begin
    clk = 0; rst_n = 0; n_cmp = 0; n_fail = 0;
    wr_en = 0; rd_en = 0; clr_err = 0; wdata = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wdata = 0;
    test_reset();
    test_fill();
    test_drain();
    test_clear_err();
    test_simultaneous();
    test_full_both();
    test_wrap();
    test_reset_traffic();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
